// File: rtl/mic_capture_pkg.sv
// rtl/mic_capture_pkg.sv - shared state enum, CSR addresses and bit indices for mic_capture_ctrl
package mic_capture_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LAUNCH  = 2'd1,
        RUN     = 2'd2,
        RELEASE = 2'd3
    } cap_state_t;

    localparam logic [2:0] ADDR_CTRL        = 3'd0;
    localparam logic [2:0] ADDR_STATUS      = 3'd1;
    localparam logic [2:0] ADDR_BUF_A       = 3'd2;
    localparam logic [2:0] ADDR_BUF_B       = 3'd3;
    localparam logic [2:0] ADDR_NUM_SAMPLES = 3'd4;
    localparam logic [2:0] ADDR_BLKCNT      = 3'd5;

    localparam int CTRL_ENABLE     = 0;
    localparam int CTRL_CONTINUOUS = 1;
    localparam int CTRL_IRQ_EN     = 2;

    localparam int STAT_BUSY       = 0;
    localparam int STAT_DONE       = 1;
    localparam int STAT_ACTIVE_BUF = 2;
    localparam int STAT_OVERRUN    = 3;
    localparam int STAT_TIMEOUT    = 4;

endpackage

// File: rtl/mic_capture_csr.sv
// rtl/mic_capture_csr.sv - CSR bank: control/buffer registers, W1C status, block counter, registered read mux
module mic_capture_csr
    import mic_capture_pkg::*;
#(
    parameter int BLKCNT_W = 16
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [2:0]  avs_address,
    input  logic        avs_read,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    output logic [31:0] avs_readdata,
    input  logic        busy,
    input  logic        active_buf,
    input  logic        set_done,
    input  logic        set_overrun,
    input  logic        set_timeout,
    input  logic        clr_enable,
    output logic        ctrl_enable,
    output logic        ctrl_continuous,
    output logic [31:0] buf_a,
    output logic [31:0] buf_b,
    output logic [31:0] num_samples,
    output logic        irq
);

    logic                ctrl_irq_en;
    logic                done;
    logic                overrun;
    logic                timeout;
    logic [BLKCNT_W-1:0] blkcnt;
    logic [31:0]         rd_mux;
    logic                wr_ctrl;
    logic                wr_status;

    assign wr_ctrl   = avs_write && (avs_address == ADDR_CTRL);
    assign wr_status = avs_write && (avs_address == ADDR_STATUS);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            ctrl_enable     <= 1'b0;
            ctrl_continuous <= 1'b0;
            ctrl_irq_en     <= 1'b0;
            buf_a           <= '0;
            buf_b           <= '0;
            num_samples     <= '0;
            done            <= 1'b0;
            overrun         <= 1'b0;
            timeout         <= 1'b0;
            blkcnt          <= '0;
            irq             <= 1'b0;
            avs_readdata    <= '0;
        end else begin
            // a software write to CTRL outranks the FSM's end-of-run enable clear
            if (wr_ctrl) begin
                ctrl_enable     <= avs_writedata[CTRL_ENABLE];
                ctrl_continuous <= avs_writedata[CTRL_CONTINUOUS];
                ctrl_irq_en     <= avs_writedata[CTRL_IRQ_EN];
            end else if (clr_enable) begin
                ctrl_enable <= 1'b0;
            end
            if (avs_write && avs_address == ADDR_BUF_A)       buf_a       <= avs_writedata;
            if (avs_write && avs_address == ADDR_BUF_B)       buf_b       <= avs_writedata;
            if (avs_write && avs_address == ADDR_NUM_SAMPLES) num_samples <= avs_writedata;
            // sticky bits: a hardware set in the same cycle as a W1C wins
            done    <= set_done    | (done    & ~(wr_status & avs_writedata[STAT_DONE]));
            overrun <= set_overrun | (overrun & ~(wr_status & avs_writedata[STAT_OVERRUN]));
            timeout <= set_timeout | (timeout & ~(wr_status & avs_writedata[STAT_TIMEOUT]));
            if (set_done) blkcnt <= blkcnt + 1'b1;
            irq <= ctrl_irq_en & (done | overrun | timeout);
            if (avs_read) avs_readdata <= rd_mux;
        end
    end

    always_comb begin
        rd_mux = '0;
        case (avs_address)
            ADDR_CTRL: begin
                rd_mux[CTRL_ENABLE]     = ctrl_enable;
                rd_mux[CTRL_CONTINUOUS] = ctrl_continuous;
                rd_mux[CTRL_IRQ_EN]     = ctrl_irq_en;
            end
            ADDR_STATUS: begin
                rd_mux[STAT_BUSY]       = busy;
                rd_mux[STAT_DONE]       = done;
                rd_mux[STAT_ACTIVE_BUF] = active_buf;
                rd_mux[STAT_OVERRUN]    = overrun;
                rd_mux[STAT_TIMEOUT]    = timeout;
            end
            ADDR_BUF_A:       rd_mux = buf_a;
            ADDR_BUF_B:       rd_mux = buf_b;
            ADDR_NUM_SAMPLES: rd_mux = num_samples;
            ADDR_BLKCNT:      rd_mux = 32'(blkcnt);
            default:          rd_mux = '0;
        endcase
    end

endmodule

// File: rtl/mic_capture_ctrl.sv
// rtl/mic_capture_ctrl.sv - mic DMA capture scheduler (single-shot / ping-pong); MIC_CAPTURE_TIMEOUT_EN adds a RUN watchdog
module mic_capture_ctrl
    import mic_capture_pkg::*;
#(
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 16777216,
    parameter int BLKCNT_W       = 16
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [2:0]  AVS_ADDRESS,
    input  logic        AVS_READ,
    input  logic        AVS_WRITE,
    input  logic [31:0] AVS_WRITEDATA,
    output logic [31:0] AVS_READDATA,
    output logic        IRQ,
    input  logic        SAMPLE_TICK,
    output logic        DMA_START,
    output logic [31:0] DMA_START_ADDR,
    output logic [31:0] DMA_NUM_SAMPLES,
    output logic        DMA_READ_READY,
    input  logic        DMA_FINISHED
);

    localparam int GAP_W = $clog2(GAP_CYCLES + 1);

    if (GAP_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("mic_capture_ctrl: GAP_CYCLES and TIMEOUT_CYCLES must be at least 1");
    end

    cap_state_t       state;
    cap_state_t       state_nxt;
    logic [GAP_W-1:0] gap_cnt;
    logic             fin_q;
    logic             fin_rise;
    logic             active_buf;
    logic             busy;
    logic             latch_en;
    logic             set_done;
    logic             set_overrun;
    logic             set_timeout;
    logic             clr_enable;
    logic             wd_expired;
    logic             ctrl_enable;
    logic             ctrl_continuous;
    logic [31:0]      buf_a;
    logic [31:0]      buf_b;
    logic [31:0]      num_samples;

    mic_capture_csr #(
        .BLKCNT_W (BLKCNT_W)
    ) u_csr (
        .CLK             (CLK),
        .RESET           (RESET),
        .avs_address     (AVS_ADDRESS),
        .avs_read        (AVS_READ),
        .avs_write       (AVS_WRITE),
        .avs_writedata   (AVS_WRITEDATA),
        .avs_readdata    (AVS_READDATA),
        .busy            (busy),
        .active_buf      (active_buf),
        .set_done        (set_done),
        .set_overrun     (set_overrun),
        .set_timeout     (set_timeout),
        .clr_enable      (clr_enable),
        .ctrl_enable     (ctrl_enable),
        .ctrl_continuous (ctrl_continuous),
        .buf_a           (buf_a),
        .buf_b           (buf_b),
        .num_samples     (num_samples),
        .irq             (IRQ)
    );

    assign fin_rise       = DMA_FINISHED & ~fin_q;
    assign busy           = (state != IDLE);
    assign DMA_START      = (state == LAUNCH) || (state == RUN);
    assign DMA_READ_READY = SAMPLE_TICK & (state == RUN);
    assign set_overrun    = SAMPLE_TICK & ((state == LAUNCH) || (state == RELEASE));

`ifdef MIC_CAPTURE_TIMEOUT_EN
    logic [31:0] wd_cnt;

    always_ff @(posedge CLK) begin
        if (RESET || state == LAUNCH) begin
            wd_cnt <= '0;
        end else if (state == RUN) begin
            wd_cnt <= wd_cnt + 32'd1;
        end
    end

    assign wd_expired = (state == RUN) && (wd_cnt == 32'(TIMEOUT_CYCLES - 1));
`else
    assign wd_expired = 1'b0;
`endif

    always_comb begin
        state_nxt   = state;
        latch_en    = 1'b0;
        set_done    = 1'b0;
        set_timeout = 1'b0;
        clr_enable  = 1'b0;
        case (state)
            IDLE: begin
                if (ctrl_enable && num_samples != 32'd0) begin
                    latch_en  = 1'b1;
                    state_nxt = LAUNCH;
                end
            end
            LAUNCH: state_nxt = RUN;
            RUN: begin
                if (fin_rise) begin
                    set_done  = 1'b1;
                    state_nxt = RELEASE;
                end else if (wd_expired) begin
                    set_timeout = 1'b1;
                    clr_enable  = 1'b1;
                    state_nxt   = IDLE;
                end
            end
            RELEASE: begin
                // exit on the cycle the gap counter steps down to zero
                if (gap_cnt == GAP_W'(1)) begin
                    if (ctrl_enable && ctrl_continuous) begin
                        latch_en  = 1'b1;
                        state_nxt = LAUNCH;
                    end else begin
                        clr_enable = 1'b1;
                        state_nxt  = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state           <= IDLE;
            fin_q           <= 1'b0;
            gap_cnt         <= '0;
            active_buf      <= 1'b0;
            DMA_START_ADDR  <= '0;
            DMA_NUM_SAMPLES <= '0;
        end else begin
            state <= state_nxt;
            fin_q <= DMA_FINISHED;
            if (set_done) begin
                active_buf <= ~active_buf;
                gap_cnt    <= GAP_W'(GAP_CYCLES);
            end else if (state == RELEASE) begin
                gap_cnt <= gap_cnt - GAP_W'(1);
            end
            // active_buf already points at the next buffer by the RELEASE exit
            if (latch_en) begin
                DMA_START_ADDR  <= active_buf ? buf_b : buf_a;
                DMA_NUM_SAMPLES <= num_samples;
            end
        end
    end

endmodule

// File: tb/tb_mic_capture_ctrl.sv
// tb/tb_mic_capture_ctrl.sv - self-checking bench for mic_capture_ctrl with a behavioural DMA model
module tb_mic_capture_ctrl;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [2:0]  AVS_ADDRESS = '0;
    logic        AVS_READ = 1'b0;
    logic        AVS_WRITE = 1'b0;
    logic [31:0] AVS_WRITEDATA = '0;
    logic [31:0] AVS_READDATA;
    logic        IRQ;
    logic        SAMPLE_TICK = 1'b0;
    logic        DMA_START;
    logic [31:0] DMA_START_ADDR;
    logic [31:0] DMA_NUM_SAMPLES;
    logic        DMA_READ_READY;
    logic        DMA_FINISHED;

    int checks = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    mic_capture_ctrl #(
        .GAP_CYCLES     (2),
        .TIMEOUT_CYCLES (100),
        .BLKCNT_W       (16)
    ) dut (
        .CLK             (CLK),
        .RESET           (RESET),
        .AVS_ADDRESS     (AVS_ADDRESS),
        .AVS_READ        (AVS_READ),
        .AVS_WRITE       (AVS_WRITE),
        .AVS_WRITEDATA   (AVS_WRITEDATA),
        .AVS_READDATA    (AVS_READDATA),
        .IRQ             (IRQ),
        .SAMPLE_TICK     (SAMPLE_TICK),
        .DMA_START       (DMA_START),
        .DMA_START_ADDR  (DMA_START_ADDR),
        .DMA_NUM_SAMPLES (DMA_NUM_SAMPLES),
        .DMA_READ_READY  (DMA_READ_READY),
        .DMA_FINISHED    (DMA_FINISHED)
    );

    // DMA model: FINISHED rises fin_delay cycles after a START rising edge, cleared by the next start
    int   fin_delay = 40;
    bit   dma_hang = 1'b0;
    logic start_q;
    bit   dma_busy;
    int   dcnt;

    always @(posedge CLK) begin
        if (RESET) begin
            DMA_FINISHED <= 1'b0;
            start_q      <= 1'b0;
            dma_busy     <= 1'b0;
            dcnt         <= 0;
        end else begin
            start_q <= DMA_START;
            if (DMA_START && !start_q) begin
                DMA_FINISHED <= 1'b0;
                dma_busy     <= 1'b1;
                dcnt         <= 0;
            end else if (dma_busy) begin
                dcnt <= dcnt + 1;
                if (dcnt == fin_delay - 1 && !dma_hang) begin
                    DMA_FINISHED <= 1'b1;
                    dma_busy     <= 1'b0;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        SAMPLE_TICK = 1'b0;
        AVS_READ = 1'b0;
        AVS_WRITE = 1'b0;
        dma_hang = 1'b0;
        cycles(2);
        RESET = 1'b0;
    endtask

    task automatic csr_write(input logic [2:0] a, input logic [31:0] d);
        AVS_ADDRESS = a;
        AVS_WRITEDATA = d;
        AVS_WRITE = 1'b1;
        cycles(1);
        AVS_WRITE = 1'b0;
    endtask

    task automatic csr_read(input logic [2:0] a, output logic [31:0] d);
        AVS_ADDRESS = a;
        AVS_READ = 1'b1;
        cycles(1);
        AVS_READ = 1'b0;
        d = AVS_READDATA;
    endtask

    task automatic read_check(input string name, input logic [2:0] a, input logic [31:0] exp);
        logic [31:0] d;
        csr_read(a, d);
        check(name, d, exp);
    endtask

    task automatic wait_start(input logic val, input int bound, input string name);
        int n = 0;
        while (DMA_START !== val && n < bound) begin
            cycles(1);
            n++;
        end
        check(name, 32'(DMA_START), 32'(val));
    endtask

    task automatic pulse_tick(input logic exp_rr, input string name);
        SAMPLE_TICK = 1'b1;
        #1;
        check(name, 32'(DMA_READ_READY), 32'(exp_rr));
        @(posedge CLK);
        #1;
        SAMPLE_TICK = 1'b0;
    endtask

    typedef struct {
        logic        wr;
        logic [2:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } csr_vec_t;

    csr_vec_t vecs[16];

    initial begin
        int gap;
        int hi;
        int n;

        vecs[0]  = '{1'b0, 3'd0, 32'h0,        32'h0};
        vecs[1]  = '{1'b0, 3'd1, 32'h0,        32'h0};
        vecs[2]  = '{1'b0, 3'd2, 32'h0,        32'h0};
        vecs[3]  = '{1'b0, 3'd3, 32'h0,        32'h0};
        vecs[4]  = '{1'b0, 3'd4, 32'h0,        32'h0};
        vecs[5]  = '{1'b0, 3'd5, 32'h0,        32'h0};
        vecs[6]  = '{1'b0, 3'd6, 32'h0,        32'h0};
        vecs[7]  = '{1'b0, 3'd7, 32'h0,        32'h0};
        vecs[8]  = '{1'b1, 3'd2, 32'hDEADBEEF, 32'hDEADBEEF};
        vecs[9]  = '{1'b1, 3'd3, 32'h12345678, 32'h12345678};
        vecs[10] = '{1'b1, 3'd4, 32'h5,        32'h5};
        vecs[11] = '{1'b1, 3'd6, 32'hFFFFFFFF, 32'h0};
        vecs[12] = '{1'b1, 3'd5, 32'h1234,     32'h0};
        vecs[13] = '{1'b1, 3'd1, 32'h1F,       32'h0};
        vecs[14] = '{1'b1, 3'd0, 32'hFFFFFFF8, 32'h0};
        vecs[15] = '{1'b1, 3'd0, 32'h6,        32'h6};

        do_reset();
        check("rst_dma_start", 32'(DMA_START), 32'h0);
        check("rst_dma_addr", DMA_START_ADDR, 32'h0);
        check("rst_dma_num", DMA_NUM_SAMPLES, 32'h0);
        check("rst_irq", 32'(IRQ), 32'h0);
        check("rst_read_ready", 32'(DMA_READ_READY), 32'h0);
        check("rst_readdata", AVS_READDATA, 32'h0);

        for (int i = 0; i < 16; i++) begin
            if (vecs[i].wr) csr_write(vecs[i].addr, vecs[i].wdata);
            read_check($sformatf("csr_vec%0d", i), vecs[i].addr, vecs[i].exp);
        end
        csr_write(3'd0, 32'h0);

        // single-shot capture
        do_reset();
        fin_delay = 40;
        csr_write(3'd2, 32'h3000_0000);
        csr_write(3'd4, 32'd8);
        csr_write(3'd0, 32'h1);
        wait_start(1'b1, 10, "ss_start");
        cycles(2);
        check("ss_addr", DMA_START_ADDR, 32'h3000_0000);
        check("ss_num", DMA_NUM_SAMPLES, 32'd8);
        wait_start(1'b0, 100, "ss_end");
        gap = 0;
        for (int i = 0; i < 4; i++) begin
            if (DMA_START === 1'b0) gap++;
            cycles(1);
        end
        check("ss_low_after", gap, 4);
        read_check("ss_status", 3'd1, 32'h6);
        read_check("ss_blkcnt", 3'd5, 32'd1);
        read_check("ss_ctrl", 3'd0, 32'h0);

        // continuous ping-pong, stopped during the fourth block
        do_reset();
        fin_delay = 20;
        csr_write(3'd2, 32'h1000);
        csr_write(3'd3, 32'h8000);
        csr_write(3'd4, 32'd4);
        csr_write(3'd0, 32'h7);
        for (int b = 0; b < 4; b++) begin
            wait_start(1'b1, 40, $sformatf("pp_start%0d", b));
            check($sformatf("pp_addr%0d", b), DMA_START_ADDR, (b % 2 == 1) ? 32'h8000 : 32'h1000);
            if (b == 3) csr_write(3'd0, 32'h6);
            wait_start(1'b0, 60, $sformatf("pp_end%0d", b));
            if (b < 3) begin
                gap = 0;
                while (DMA_START === 1'b0 && gap < 10) begin
                    gap++;
                    cycles(1);
                end
                check($sformatf("pp_gap%0d", b), gap, 2);
                if (b == 0) check("pp_irq_first", 32'(IRQ), 32'h1);
            end
        end
        cycles(5);
        check("pp_no_fifth", 32'(DMA_START), 32'h0);
        read_check("pp_blkcnt", 3'd5, 32'd4);
        read_check("pp_status", 3'd1, 32'h2);
        read_check("pp_ctrl", 3'd0, 32'h6);
        check("pp_irq_held", 32'(IRQ), 32'h1);
        csr_write(3'd1, 32'h2);
        cycles(2);
        check("pp_irq_cleared", 32'(IRQ), 32'h0);

        // sample gating and overrun
        do_reset();
        fin_delay = 40;
        csr_write(3'd2, 32'h100);
        csr_write(3'd4, 32'd4);
        pulse_tick(1'b0, "gt_idle_rr");
        read_check("gt_idle_status", 3'd1, 32'h0);
        csr_write(3'd0, 32'h5);
        wait_start(1'b1, 10, "gt_start");
        cycles(3);
        for (int k = 0; k < 3; k++) begin
            pulse_tick(1'b1, $sformatf("gt_run_rr%0d", k));
            cycles(9);
        end
        wait_start(1'b0, 60, "gt_end");
        pulse_tick(1'b0, "gt_release_rr");
        cycles(3);
        check("gt_irq", 32'(IRQ), 32'h1);
        read_check("gt_status", 3'd1, 32'hE);
        csr_write(3'd1, 32'h2);
        cycles(2);
        check("gt_irq_overrun_only", 32'(IRQ), 32'h1);
        read_check("gt_status_no_done", 3'd1, 32'hC);
        csr_write(3'd1, 32'h8);
        cycles(2);
        check("gt_irq_clear", 32'(IRQ), 32'h0);
        read_check("gt_status_clear", 3'd1, 32'h4);

        // stop mid-run: current block completes, no relaunch
        do_reset();
        fin_delay = 40;
        csr_write(3'd2, 32'h40);
        csr_write(3'd4, 32'd2);
        csr_write(3'd0, 32'h3);
        wait_start(1'b1, 10, "sm_start");
        pulse_tick(1'b0, "sm_launch_rr");
        cycles(4);
        csr_write(3'd0, 32'h0);
        cycles(5);
        check("sm_hold", 32'(DMA_START), 32'h1);
        wait_start(1'b0, 60, "sm_end");
        hi = 0;
        for (int i = 0; i < 10; i++) begin
            cycles(1);
            if (DMA_START === 1'b1) hi++;
        end
        check("sm_no_relaunch", hi, 0);
        read_check("sm_blkcnt", 3'd5, 32'd1);
        read_check("sm_status", 3'd1, 32'hE);

        // enable with NUM_SAMPLES = 0 stays idle
        do_reset();
        csr_write(3'd0, 32'h1);
        cycles(5);
        check("num0_dma_start", 32'(DMA_START), 32'h0);
        read_check("num0_status", 3'd1, 32'h0);
        csr_write(3'd0, 32'h0);

        // W1C of done on the very cycle FINISHED rises
        do_reset();
        fin_delay = 10;
        csr_write(3'd2, 32'h0);
        csr_write(3'd4, 32'd1);
        csr_write(3'd0, 32'h1);
        wait_start(1'b1, 10, "wc_start");
        n = 0;
        while (DMA_FINISHED !== 1'b1 && n < 40) begin
            cycles(1);
            n++;
        end
        check("wc_fin_seen", 32'(DMA_FINISHED), 32'h1);
        csr_write(3'd1, 32'h2);
        cycles(4);
        read_check("wc_status", 3'd1, 32'h6);

        // reset during RUN
        do_reset();
        fin_delay = 40;
        csr_write(3'd2, 32'h55);
        csr_write(3'd4, 32'd3);
        csr_write(3'd0, 32'h7);
        wait_start(1'b1, 10, "rr_start");
        pulse_tick(1'b0, "rr_launch_rr");
        cycles(3);
        read_check("rr_pre_buf_a", 3'd2, 32'h55);
        check("rr_pre_irq", 32'(IRQ), 32'h1);
        check("rr_pre_addr", DMA_START_ADDR, 32'h55);
        SAMPLE_TICK = 1'b1;
        RESET = 1'b1;
        cycles(1);
        check("rr_dma_start", 32'(DMA_START), 32'h0);
        check("rr_dma_addr", DMA_START_ADDR, 32'h0);
        check("rr_dma_num", DMA_NUM_SAMPLES, 32'h0);
        check("rr_irq", 32'(IRQ), 32'h0);
        check("rr_read_ready", 32'(DMA_READ_READY), 32'h0);
        check("rr_readdata", AVS_READDATA, 32'h0);
        SAMPLE_TICK = 1'b0;
        RESET = 1'b0;

        // DMA that never finishes
        do_reset();
        dma_hang = 1'b1;
        csr_write(3'd2, 32'h200);
        csr_write(3'd4, 32'd6);
        csr_write(3'd0, 32'h1);
        wait_start(1'b1, 10, "to_start");
`ifdef MIC_CAPTURE_TIMEOUT_EN
        hi = 0;
        while (DMA_START === 1'b1 && hi < 200) begin
            hi++;
            cycles(1);
        end
        check("to_high_cycles", hi, 101);
        check("to_dma_start", 32'(DMA_START), 32'h0);
        read_check("to_status", 3'd1, 32'h10);
        read_check("to_ctrl", 3'd0, 32'h0);
`else
        cycles(150);
        check("hang_dma_start", 32'(DMA_START), 32'h1);
        read_check("hang_status", 3'd1, 32'h1);
`endif
        do_reset();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
